// File: rtl/prog_loader.sv
// Program-memory loader: accepts a length-prefixed, XOR-checksummed byte stream and
// drives the memory write port while holding the CPU, then reports done/error status.
module prog_loader #(
    parameter int DATAWIDTH = 8,
    parameter int ADDWIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [DATAWIDTH-1:0] byte_data,
    output logic                 byte_ready,
    output logic                 wrEn,
    output logic [ADDWIDTH-1:0]  writeAdd,
    output logic [DATAWIDTH-1:0] writeData,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int CW = DATAWIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** ADDWIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_LOAD = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [DATAWIDTH-1:0] xor_accum(
        input logic [DATAWIDTH-1:0] acc,
        input logic [DATAWIDTH-1:0] b
    );
        return acc ^ b;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [CW-1:0]        len_r;
    logic [CW-1:0]        cnt_r;
    logic [DATAWIDTH-1:0] csum_r;
    logic                 wr_en_r;
    logic [ADDWIDTH-1:0]  write_add_r;
    logic [DATAWIDTH-1:0] write_data_r;
    logic                 cpu_hold_r;
    logic                 load_done_r;
    logic                 load_err_r;

    logic                 xfer_s;
    logic                 busy_nxt_s;
    logic [CW-1:0]        len_ext_s;
    logic [CW-1:0]        len_val_s;
    logic                 len_ok_s;
    logic                 last_s;
    logic                 enter_len_s;
    logic                 take_len_s;
    logic                 wr_s;
    logic                 set_done_s;
    logic                 set_err_s;

    assign byte_ready = (state_r == S_LEN) || (state_r == S_LOAD) || (state_r == S_CHK);
    assign xfer_s     = byte_valid & byte_ready;
    assign busy_nxt_s = (state_nxt_s == S_LEN) || (state_nxt_s == S_LOAD) || (state_nxt_s == S_CHK);
    // A length byte of zero encodes a full-depth load.
    assign len_ext_s  = {1'b0, byte_data};
    assign len_val_s  = (byte_data == {DATAWIDTH{1'b0}}) ? DEPTH_C : len_ext_s;
    assign len_ok_s   = (len_val_s <= DEPTH_C);
    assign last_s     = ((cnt_r + {{(CW-1){1'b0}}, 1'b1}) == len_r);

    assign wrEn      = wr_en_r;
    assign writeAdd  = write_add_r;
    assign writeData = write_data_r;
    assign cpu_hold  = cpu_hold_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nxt_s = state_r;
        enter_len_s = 1'b0;
        take_len_s  = 1'b0;
        wr_s        = 1'b0;
        set_done_s  = 1'b0;
        set_err_s   = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt_s = S_LEN;
                    enter_len_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LEN: begin
                if (xfer_s && len_ok_s) begin
                    state_nxt_s = S_LOAD;
                    take_len_s  = 1'b1;
                end else if (xfer_s) begin
                    state_nxt_s = S_IDLE;
                    set_err_s   = 1'b1;
                end else begin
                    state_nxt_s = S_LEN;
                end
            end
            S_LOAD: begin
                if (xfer_s) begin
                    wr_s        = 1'b1;
                    state_nxt_s = last_s ? S_CHK : S_LOAD;
                end else begin
                    state_nxt_s = S_LOAD;
                end
            end
            S_CHK: begin
                if (xfer_s && (byte_data == csum_r)) begin
                    state_nxt_s = S_DONE;
                    set_done_s  = 1'b1;
                end else if (xfer_s) begin
                    state_nxt_s = S_IDLE;
                    set_err_s   = 1'b1;
                end else begin
                    state_nxt_s = S_CHK;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            len_r        <= {CW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            csum_r       <= {DATAWIDTH{1'b0}};
            wr_en_r      <= 1'b0;
            write_add_r  <= {ADDWIDTH{1'b0}};
            write_data_r <= {DATAWIDTH{1'b0}};
            cpu_hold_r   <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cpu_hold_r <= busy_nxt_s;
            wr_en_r    <= wr_s;
            if (enter_len_s) begin
                cnt_r       <= {CW{1'b0}};
                csum_r      <= {DATAWIDTH{1'b0}};
                load_done_r <= 1'b0;
                load_err_r  <= 1'b0;
            end
            if (take_len_s) begin
                len_r <= len_val_s;
            end
            // Write port only updates on a write so address/data hold between bytes.
            if (wr_s) begin
                write_add_r  <= cnt_r[ADDWIDTH-1:0];
                write_data_r <= byte_data;
                csum_r       <= xor_accum(csum_r, byte_data);
                cnt_r        <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
            if (set_done_s) begin
                load_done_r <= 1'b1;
            end
            if (set_err_s) begin
                load_err_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load scenarios checked against a
// stream-level reference model, plus directed reset / basic / oversize / abort sequences.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst, start, byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready, wrEn, cpu_hold, load_done, load_err;
    logic [6:0] writeAdd;
    logic [7:0] writeData;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [6:0] obs_addr[$];
    logic [7:0] obs_data[$];
    int         obs_cyc[$];

    prog_loader #(.DATAWIDTH(8), .ADDWIDTH(7)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .wrEn(wrEn), .writeAdd(writeAdd), .writeData(writeData),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Write monitor: captures every memory write mid-cycle.
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (wrEn === 1'b1) begin
            obs_addr.push_back(writeAdd);
            obs_data.push_back(writeData);
            obs_cyc.push_back(cycle);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Offer one byte, optionally with random idle cycles, until it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        guard = 0;
        if (stall) begin
            while ($urandom_range(0, 2) == 0) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                step();
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
        step();
        byte_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0] len_byte;
        bit         corrupt;
        bit         stall;
        bit         exp_done;
        bit         exp_err;
        int         exp_nwr;
    } vec_t;

    vec_t vecs[7];

    // Reference model: a stream is the length byte, payload and checksum; writes are (i, payload[i]).
    task automatic run_vec(input vec_t v, input int idx);
        int         n;
        bit         len_ok;
        logic [7:0] payload[$];
        logic [7:0] csum;
        int         bad;
        n      = (v.len_byte == 8'd0) ? 128 : int'(v.len_byte);
        len_ok = (n <= 128);
        csum   = 8'd0;
        payload.delete();
        if (len_ok) begin
            for (int i = 0; i < n; i++) begin
                payload.push_back(8'($urandom));
                csum = csum ^ payload[i];
            end
        end
        if (v.corrupt) csum = csum ^ 8'h5A;
        clear_obs();
        do_start();
        chk($sformatf("v%0d_hold_on", idx), 32'(cpu_hold), 32'd1);
        chk($sformatf("v%0d_flags_clr", idx), {30'd0, load_done, load_err}, 32'd0);
        send_byte(v.len_byte, v.stall);
        if (len_ok) begin
            foreach (payload[i]) send_byte(payload[i], v.stall);
            send_byte(csum, v.stall);
        end
        step();
        chk($sformatf("v%0d_done", idx), 32'(load_done), 32'(v.exp_done));
        chk($sformatf("v%0d_err", idx), 32'(load_err), 32'(v.exp_err));
        chk($sformatf("v%0d_hold_off", idx), 32'(cpu_hold), 32'd0);
        chk($sformatf("v%0d_ready_off", idx), 32'(byte_ready), 32'd0);
        chk($sformatf("v%0d_nwr", idx), 32'(obs_addr.size()), 32'(v.exp_nwr));
        chk($sformatf("v%0d_model_nwr", idx), 32'(obs_addr.size()), 32'(payload.size()));
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < payload.size(); i++) begin
            if (obs_addr[i] !== 7'(i) || obs_data[i] !== payload[i]) bad++;
        end
        chk($sformatf("v%0d_write_content", idx), 32'(bad), 32'd0);
    endtask

    initial begin
        logic [7:0] basic[5];
        int         nw;

        rst = 1'b1; start = 1'b1; byte_valid = 1'b1; byte_data = 8'hFF;

        // Reset held two cycles with start and byte_valid asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_outputs", {25'd0, byte_ready, wrEn, cpu_hold, load_done, load_err, 2'd0}, 32'd0);
            chk("rst_write_port", {17'd0, writeAdd, writeData}, 32'd0);
        end
        rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
        step();

        // Basic load with consecutive writes; start taken while a byte is also offered.
        basic[0] = 8'h03; basic[1] = 8'hA1; basic[2] = 8'hB2; basic[3] = 8'hC3; basic[4] = 8'hD0;
        clear_obs();
        byte_valid = 1'b1; byte_data = 8'h03;
        do_start();
        chk("basic_ready", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 5; i++) send_byte(basic[i], 1'b0);
        step();
        chk("basic_nwr", 32'(obs_addr.size()), 32'd3);
        if (obs_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("basic_wr%0d", i), {23'd0, obs_addr[i], obs_data[i]}, {23'd0, 7'(i), basic[i+1]});
            end
            chk("basic_b2b", 32'(obs_cyc[2] - obs_cyc[0]), 32'd2);
        end
        chk("basic_done", {30'd0, load_done, load_err}, 32'd2);
        chk("basic_hold", 32'(cpu_hold), 32'd0);
        chk("basic_wr_idle", 32'(wrEn), 32'd0);
        chk("basic_hold_data", {23'd0, writeAdd, writeData}, {23'd0, 7'd2, 8'hC3});

        // Oversize length: rejected, no writes, ready drops right after the transfer.
        clear_obs();
        do_start();
        byte_valid = 1'b1; byte_data = 8'h81;
        chk("big_ready_before", 32'(byte_ready), 32'd1);
        step();
        byte_valid = 1'b0;
        chk("big_ready_after", 32'(byte_ready), 32'd0);
        chk("big_hold", 32'(cpu_hold), 32'd0);
        chk("big_err", {30'd0, load_done, load_err}, 32'd1);
        step();
        chk("big_nwr", 32'(obs_addr.size()), 32'd0);

        // Table of load scenarios.
        vecs[0] = '{len_byte: 8'h02, corrupt: 1'b1, stall: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 2};
        vecs[1] = '{len_byte: 8'h00, corrupt: 1'b0, stall: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 128};
        vecs[2] = '{len_byte: 8'h80, corrupt: 1'b0, stall: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 128};
        vecs[3] = '{len_byte: 8'h01, corrupt: 1'b0, stall: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 1};
        vecs[4] = '{len_byte: 8'hFF, corrupt: 1'b0, stall: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 0};
        vecs[5] = '{len_byte: 8'h11, corrupt: 1'b0, stall: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_nwr: 17};
        vecs[6] = '{len_byte: 8'h05, corrupt: 1'b1, stall: 1'b1, exp_done: 1'b0, exp_err: 1'b1, exp_nwr: 5};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Full-depth load must end on the top address.
        clear_obs();
        do_start();
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 128; i++) send_byte(8'(i), 1'b0);
        send_byte(8'h00, 1'b0);
        step();
        chk("full_nwr", 32'(obs_addr.size()), 32'd128);
        if (obs_addr.size() == 128) chk("full_last", {23'd0, obs_addr[127], obs_data[127]}, {23'd0, 7'h7F, 8'h7F});
        chk("full_done", {30'd0, load_done, load_err}, 32'd2);

        // Start while busy is ignored; then abort by reset mid-load.
        clear_obs();
        do_start();
        send_byte(8'h0A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) start = 1'b1;
            send_byte(8'h40 + 8'(i), 1'b1);
            start = 1'b0;
        end
        chk("abort_hold_pre", 32'(cpu_hold), 32'd1);
        rst = 1'b1; byte_valid = 1'b1; byte_data = 8'h99;
        step();
        rst = 1'b0;
        chk("abort_outputs", {27'd0, byte_ready, wrEn, cpu_hold, load_done, load_err}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        byte_valid = 1'b0;
        nw = obs_addr.size();
        chk("abort_nwr", 32'(nw), 32'd4);
        for (int i = 0; i < nw && i < 4; i++) begin
            chk($sformatf("abort_wr%0d", i), {23'd0, obs_addr[i], obs_data[i]}, {23'd0, 7'(i), 8'h40 + 8'(i)});
        end
        chk("abort_idle_ready", 32'(byte_ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
